// File: rtl/booth_mult_seq.sv
// ============================================================================
// booth_mult_seq
// ----------------------------------------------------------------------------
// Sequential Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, with run-time
// signed/unsigned operand selection.
//
// A controller raises 'start' while the unit is idle. The operands and the
// 'tc' mode bit are captured on that edge. The unit then runs ITER Booth
// steps, spends one cycle in DONE, loads 'ab' and pulses 'done' for one
// cycle. 'ab' keeps its value until the next completion or until reset.
//
// Build option (macro):
//   RADIX4_EN  undefined : radix-2 Booth, 1-bit shift per step, ITER = WIDTH+1
//   RADIX4_EN  defined   : modified (radix-4) Booth, 2-bit shift per step,
//                          ITER = WIDTH/2+1; WIDTH must be even
//   Both builds give the same results and the same port behaviour. Only the
//   latency differs.
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst    in   1        synchronous active-high reset; aborts any operation
//   start  in   1        request; only sampled while idle
//   a      in   WIDTH    multiplicand
//   b      in   WIDTH    multiplier
//   tc     in   1        1 = two's-complement operands, 0 = unsigned
//   ab     out  2*WIDTH  product register
//   busy   out  1        high from the cycle after acceptance through DONE
//   done   out  1        one-cycle pulse when ab has just been loaded
//
// Timing: start is accepted at edge E0. ab and done update at edge E(ITER+1).
// busy is high for ITER+1 cycles.
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 tc,
    output logic [2*WIDTH-1:0]   ab,
    output logic                 busy,
    output logic                 done
);

    // ------------------------------------------------------------------------
    // Derived sizes
    //   EW   : extended operand width. It carries the sign/zero extension, so
    //          one recoding scheme handles both signed and unsigned operands.
    //   AW   : accumulator width. It is one bit wider than EW so that adding
    //          +/-M (or +/-2M in radix-4) can never overflow.
    //   SH   : number of multiplier bits retired by each step.
    //   ITER : number of Booth steps. ITER*SH == EW, so after the last step
    //          {acc, mult} holds the complete product.
    // ------------------------------------------------------------------------
`ifdef RADIX4_EN
    localparam int EW   = WIDTH + 2;
    localparam int SH   = 2;
    localparam int ITER = WIDTH / 2 + 1;
`else
    localparam int EW   = WIDTH + 1;
    localparam int SH   = 1;
    localparam int ITER = WIDTH + 1;
`endif
    localparam int AW = EW + 1;
    localparam int PW = AW + EW + 1;          // {acc, mult, q-1}
    localparam int CW = $clog2(ITER + 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 4) begin : g_width_min_chk
            $error("booth_mult_seq: WIDTH must be >= 4");
        end
`ifdef RADIX4_EN
        if ((WIDTH % 2) != 0) begin : g_width_even_chk
            $error("booth_mult_seq: WIDTH must be even when RADIX4_EN is defined");
        end
`endif
    endgenerate

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_reg,  state_next;
    logic [AW-1:0]       acc_reg,    acc_next;
    logic [EW-1:0]       mult_reg,   mult_next;
    logic                qm1_reg,    qm1_next;
    logic [EW-1:0]       mcand_reg,  mcand_next;
    logic [CW-1:0]       count_reg,  count_next;
    logic [2*WIDTH-1:0]  ab_reg,     ab_next;
    logic                busy_reg,   busy_next;
    logic                done_reg,   done_next;

    // ------------------------------------------------------------------------
    // Operand extension. The low WIDTH bits pass straight through. Each extra
    // bit copies the MSB in two's-complement mode and is zero otherwise.
    // ------------------------------------------------------------------------
    wire [EW-1:0] a_ext;
    wire [EW-1:0] b_ext;

    assign a_ext[WIDTH-1:0] = a;
    assign b_ext[WIDTH-1:0] = b;

    genvar gi;
    generate
        for (gi = WIDTH; gi < EW; gi++) begin : g_ext
            assign a_ext[gi] = tc & a[WIDTH-1];
            assign b_ext[gi] = tc & b[WIDTH-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // One Booth step
    // The recoded digit selects an addend from the multiplicand. That addend
    // is added to the accumulator. Then the whole {acc, mult, q-1} word is
    // shifted arithmetically right by SH.
    // ------------------------------------------------------------------------
    logic [AW-1:0] m_ext;        // multiplicand, sign-extended to AW bits
    logic [AW-1:0] addend;
    logic [AW-1:0] sum;
    logic [PW-1:0] shifted;
`ifdef RADIX4_EN
    logic [AW-1:0] m2_ext;       // 2*M; the AW width holds it without overflow
`endif

    always_comb begin
        m_ext  = {mcand_reg[EW-1], mcand_reg};
        addend = '0;
`ifdef RADIX4_EN
        m2_ext = {m_ext[AW-2:0], 1'b0};
        case ({mult_reg[1:0], qm1_reg})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m2_ext;
            3'b100:         addend = -m2_ext;
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;     // 000 / 111
        endcase
`else
        case ({mult_reg[0], qm1_reg})
            2'b01:   addend = m_ext;
            2'b10:   addend = -m_ext;
            default: addend = '0;            // 00 / 11
        endcase
`endif
        sum     = acc_reg + addend;
        shifted = $signed({sum, mult_reg, qm1_reg}) >>> SH;
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        mult_next  = mult_reg;
        qm1_next   = qm1_reg;
        mcand_next = mcand_reg;
        count_next = count_reg;
        ab_next    = ab_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;                   // done never lasts more than one cycle

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    mcand_next = a_ext;
                    mult_next  = b_ext;
                    acc_next   = '0;
                    qm1_next   = 1'b0;
                    count_next = CW'(ITER);
                    busy_next  = 1'b1;
                    state_next = S_CALC;
                end
            end

            S_CALC: begin
                acc_next   = shifted[PW-1 -: AW];
                mult_next  = shifted[EW:1];
                qm1_next   = shifted[0];
                count_next = count_reg - 1'b1;
                // The step taken with count == 1 is the last one.
                if (count_reg == CW'(1)) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                // Every multiplier bit has been shifted out, so {acc, mult}
                // now holds the exact product. Keep only the low 2*WIDTH bits.
                ab_next    = (2*WIDTH)'({acc_reg, mult_reg});
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers. rst takes priority over everything, including start.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            mult_reg  <= '0;
            qm1_reg   <= 1'b0;
            mcand_reg <= '0;
            count_reg <= '0;
            ab_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            mult_reg  <= mult_next;
            qm1_reg   <= qm1_next;
            mcand_reg <= mcand_next;
            count_reg <= count_next;
            ab_reg    <= ab_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign ab   = ab_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

`ifdef RADIX4_EN
    localparam int WIDTH = 16;
    localparam int ITER  = WIDTH / 2 + 1;
`else
    localparam int WIDTH = 8;
    localparam int ITER  = WIDTH + 1;
`endif
    localparam int PW2    = 2 * WIDTH;
    localparam int BUDGET = 4 * ITER + 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               tc;
    logic [PW2-1:0]     ab;
    logic               busy;
    logic               done;

    booth_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .tc    (tc),
        .ab    (ab),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic [PW2-1:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference product: ordinary integer multiply of the interpreted operands
    function automatic logic [PW2-1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic t);
        longint xv, yv;
        xv = longint'(x);
        yv = longint'(y);
        if (t && x[WIDTH-1]) xv = xv - (longint'(1) << WIDTH);
        if (t && y[WIDTH-1]) yv = yv - (longint'(1) << WIDTH);
        return PW2'(xv * yv);
    endfunction

    // Sample/drive point: 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one edge; record the expectation
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic t);
        a     = x;
        b     = y;
        tc    = t;
        start = 1'b1;
        exp_q.push_back(model(x, y, t));
        tick();
        start = 1'b0;
    endtask

    function automatic logic [PW2-1:0] pop_exp();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 'x;
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a = '0; b = '0; tc = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (ab !== '0) $display("FAIL reset_ab got=%h want=0", ab); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
        rst = 1'b0;
        tick();
        $display("reset ab=%h busy=%b done=%b", ab, busy, done);
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] va[6];
        logic [WIDTH-1:0] vb[6];
        logic             vt[6];
        logic [WIDTH-1:0] vmax, vmin;
        logic [PW2-1:0]   exp_v;
        int n, busy_cnt;
        vmax = '1;
        vmin = '0;
        vmin[WIDTH-1] = 1'b1;
        va[0] = WIDTH'(3);  vb[0] = WIDTH'(17); vt[0] = 1'b0;
        va[1] = vmax;       vb[1] = vmax;       vt[1] = 1'b0;
        va[2] = vmin;       vb[2] = vmin;       vt[2] = 1'b1;
        va[3] = WIDTH'(-3); vb[3] = WIDTH'(17); vt[3] = 1'b1;
        va[4] = vmax;       vb[4] = WIDTH'(1);  vt[4] = 1'b1;
        va[5] = vmin;       vb[5] = vmax;       vt[5] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            issue(va[k], vb[k], vt[k]);
            busy_cnt = busy ? 1 : 0;
            n = 0;
            for (int i = 1; i <= BUDGET; i++) begin
                tick();
                if (busy) busy_cnt++;
                if (done) begin
                    n = i;
                    break;
                end
            end
            exp_v = pop_exp();
            total_cnt++;
            if (n !== ITER + 1) $display("FAIL basic_latency[%0d] got=%0d want=%0d", k, n, ITER + 1);
            else pass_cnt++;
            total_cnt++;
            if (busy_cnt !== ITER + 1) $display("FAIL basic_busy_len[%0d] got=%0d want=%0d", k, busy_cnt, ITER + 1);
            else pass_cnt++;
            total_cnt++;
            if (ab !== exp_v) $display("FAIL basic_ab[%0d] got=%h want=%h", k, ab, exp_v);
            else pass_cnt++;
            $display("basic a=%h b=%h tc=%0d ab=%h latency=%0d", va[k], vb[k], vt[k], ab, n);
            tick();
            total_cnt++;
            if (done !== 1'b0) $display("FAIL basic_done_pulse[%0d] got=%b want=0", k, done);
            else pass_cnt++;
            total_cnt++;
            if (ab !== exp_v) $display("FAIL basic_ab_hold[%0d] got=%h want=%h", k, ab, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        logic [PW2-1:0] exp_v;
        int n, extra;
        issue(WIDTH'(7), WIDTH'(7), 1'b0);
        n = 0;
        repeat (3) begin
            tick();
            n++;
        end
        a = WIDTH'(2);
        b = WIDTH'(2);
        start = 1'b1;
        tick();
        n++;
        start = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            n++;
            if (done) break;
        end
        exp_v = pop_exp();
        total_cnt++;
        if (done !== 1'b1 || n !== ITER + 1) $display("FAIL ignore_latency got=%0d want=%0d", n, ITER + 1);
        else pass_cnt++;
        total_cnt++;
        if (ab !== exp_v) $display("FAIL ignore_ab got=%h want=%h", ab, exp_v);
        else pass_cnt++;
        $display("ignore_start a=7 b=7 ab=%h latency=%0d", ab, n);
        extra = 0;
        for (int i = 0; i < ITER + 3; i++) begin
            tick();
            if (done) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL ignore_extra_done got=%0d want=0", extra);
        else pass_cnt++;
        total_cnt++;
        if (ab !== exp_v) $display("FAIL ignore_ab_after got=%h want=%h", ab, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [PW2-1:0] exp_v;
        int n;
        issue(WIDTH'(7), WIDTH'(7), 1'b0);
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (done) break;
        end
        exp_v = pop_exp();
        total_cnt++;
        if (done !== 1'b1 || ab !== exp_v) $display("FAIL b2b_first_ab got=%h done=%b want=%h", ab, done, exp_v);
        else pass_cnt++;
        $display("b2b first a=7 b=7 ab=%h", ab);
        // Re-request in the done cycle; the unit is idle here.
        a = WIDTH'(5);
        b = WIDTH'(6);
        tc = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(WIDTH'(5), WIDTH'(6), 1'b0));
        tick();
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL b2b_accept_busy got=%b want=1", busy);
        else pass_cnt++;
        n = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
        exp_v = pop_exp();
        total_cnt++;
        if (n !== ITER + 1) $display("FAIL b2b_latency got=%0d want=%0d", n, ITER + 1);
        else pass_cnt++;
        total_cnt++;
        if (ab !== exp_v) $display("FAIL b2b_second_ab got=%h want=%h", ab, exp_v);
        else pass_cnt++;
        $display("b2b second a=5 b=6 ab=%h latency=%0d", ab, n);
        tick();
    endtask

    task automatic test_hold_start();
        logic [PW2-1:0] exp_v;
        int dcount, d1, extra;
        a = WIDTH'(3);
        b = WIDTH'(5);
        tc = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(WIDTH'(3), WIDTH'(5), 1'b0));
        exp_q.push_back(model(WIDTH'(3), WIDTH'(5), 1'b0));
        dcount = 0;
        d1 = 0;
        for (int i = 1; i <= 3 * (ITER + 2); i++) begin
            tick();
            if (done) begin
                exp_v = pop_exp();
                total_cnt++;
                if (ab !== exp_v) $display("FAIL hold_ab[%0d] got=%h want=%h", dcount, ab, exp_v);
                else pass_cnt++;
                $display("hold_start a=3 b=5 ab=%h at=%0d", ab, i);
                if (dcount == 0) d1 = i;
                dcount++;
                if (dcount == 2) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        total_cnt++;
        if (dcount !== 2) $display("FAIL hold_count got=%0d want=2", dcount);
        else pass_cnt++;
        total_cnt++;
        if (d1 !== ITER + 2) $display("FAIL hold_first_latency got=%0d want=%0d", d1, ITER + 2);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < ITER + 3; i++) begin
            tick();
            if (done) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL hold_extra_done got=%0d want=0", extra);
        else pass_cnt++;
    endtask

    task automatic test_rst_abort();
        logic [PW2-1:0] exp_v;
        int extra, n;
        issue(WIDTH'(3), WIDTH'(17), 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_v = exp_q.pop_back();          // aborted operation: no result expected
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL abort_done got=%b want=0", done); else pass_cnt++;
        total_cnt++;
        if (ab !== '0) $display("FAIL abort_ab got=%h want=0", ab); else pass_cnt++;
        $display("rst_abort busy=%b done=%b ab=%h", busy, done, ab);
        extra = 0;
        for (int i = 0; i < ITER + 4; i++) begin
            tick();
            if (done) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL abort_no_done got=%0d want=0", extra);
        else pass_cnt++;
        issue(WIDTH'(9), WIDTH'(11), 1'b0);
        n = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
        exp_v = pop_exp();
        total_cnt++;
        if (n !== ITER + 1) $display("FAIL abort_recover_latency got=%0d want=%0d", n, ITER + 1);
        else pass_cnt++;
        total_cnt++;
        if (ab !== exp_v) $display("FAIL abort_recover_ab got=%h want=%h", ab, exp_v);
        else pass_cnt++;
        $display("rst_recover a=9 b=11 ab=%h latency=%0d", ab, n);
        tick();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] x, y;
        logic             t;
        logic [PW2-1:0]   exp_v;
        int n;
        for (int k = 0; k < 16; k++) begin
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            t = 1'($urandom_range(0, 1));
            issue(x, y, t);
            n = 0;
            for (int i = 1; i <= BUDGET; i++) begin
                tick();
                if (done) begin
                    n = i;
                    break;
                end
            end
            exp_v = pop_exp();
            total_cnt++;
            if (n !== ITER + 1) $display("FAIL rand_latency[%0d] got=%0d want=%0d", k, n, ITER + 1);
            else pass_cnt++;
            total_cnt++;
            if (ab !== exp_v) $display("FAIL rand_ab[%0d] a=%h b=%h tc=%0d got=%h want=%h", k, x, y, t, ab, exp_v);
            else pass_cnt++;
            $display("random a=%h b=%h tc=%0d ab=%h", x, y, t, ab);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tc    = 1'b0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_hold_start();
        test_rst_abort();
        test_random();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
